// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU issue arbiter: control-word layout and the
// CDB-usage predicate evaluated on the issued op.
package alu_arb_pkg;

  localparam int CTRL_W = 66;

  // Control word, MSB to LSB: WarpID[3] Instr[32] Dst[5] Imme[16] Imme_Valid RegWrite ALUop[4] BEQ BLT ScbID[2]
  localparam int WARPID_LSB   = 63;
  localparam int INSTR_LSB    = 31;
  localparam int DST_LSB      = 26;
  localparam int IMME_LSB     = 10;
  localparam int IMMEV_BIT    = 9;
  localparam int REGWRITE_BIT = 8;
  localparam int ALUOP_LSB    = 4;
  localparam int BEQ_BIT      = 3;
  localparam int BLT_BIT      = 2;
  localparam int SCBID_LSB    = 0;

  // Branches and non-writing ops never drive the CDB, so they are never held.
  function automatic logic needs_cdb(input logic [CTRL_W-1:0] ctrl);
    return ctrl[REGWRITE_BIT] & ~ctrl[BEQ_BIT] & ~ctrl[BLT_BIT];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant scanning upward from rr_ptr with wrap;
// the pointer advances past the winner on every grant.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         enable,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] rr_ptr_r;
  logic [N-1:0]  gnt_s;
  logic          found_s;
  logic [PW-1:0] gnt_idx_s;
  logic [PW-1:0] idx_s;
  logic          take_s;
  int            sum_s;

  // Find the first requester at or after rr_ptr; grants are suppressed in reset.
  always_comb begin
    gnt_s     = '0;
    found_s   = 1'b0;
    gnt_idx_s = '0;
    idx_s     = '0;
    take_s    = 1'b0;
    sum_s     = 0;
    if (enable && !rst) begin
      for (int i = 0; i < N; i++) begin
        sum_s        = (int'(rr_ptr_r) + i) % N;
        idx_s        = sum_s[PW-1:0];
        take_s       = req[idx_s] & ~found_s;
        gnt_s[idx_s] = gnt_s[idx_s] | take_s;
        gnt_idx_s    = take_s ? idx_s : gnt_idx_s;
        found_s      = found_s | take_s;
      end
    end else begin
      gnt_s   = '0;
      found_s = 1'b0;
    end
  end

  assign gnt = gnt_s;

  // Advance the pointer one past the granted entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r <= '0;
    end else if (found_s) begin
      rr_ptr_r <= (gnt_idx_s == PW'(N - 1)) ? '0 : gnt_idx_s + PW'(1);
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Issue controller between operand-collector entries and the ALU. Optional
// performance counters are built only when ALU_ARB_PERF_EN is defined.
module alu_issue_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_OC      = 4,
  parameter int NUM_THREADS = 8,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_OC-1:0]                         Valid_OC_Arb,
  input  logic [NUM_OC*CTRL_W-1:0]                  Ctrl_OC_Arb,
  input  logic [NUM_OC*NUM_THREADS*DATA_WIDTH-1:0]  Src1_Data_OC_Arb,
  input  logic [NUM_OC*NUM_THREADS*DATA_WIDTH-1:0]  Src2_Data_OC_Arb,
  output logic [NUM_OC-1:0]                         Grant_Arb_OC,
  input  logic                                      CDB_Stall_MULT_Arb,
`ifdef ALU_ARB_PERF_EN
  output logic [31:0]                               Perf_Issue_Cnt,
  output logic [31:0]                               Perf_Stall_Cnt,
`endif
  output logic                                      Valid_Arb_ALU,
  output logic [CTRL_W-1:0]                         Ctrl_Arb_ALU,
  output logic [NUM_THREADS*DATA_WIDTH-1:0]         Src1_Data_Arb_ALU,
  output logic [NUM_THREADS*DATA_WIDTH-1:0]         Src2_Data_Arb_ALU
);

  localparam int VEC_W = NUM_THREADS * DATA_WIDTH;

  logic              valid_r;
  logic [CTRL_W-1:0] ctrl_r;
  logic [VEC_W-1:0]  src1_r;
  logic [VEC_W-1:0]  src2_r;

  logic              hold_s;
  logic              can_load_s;
  logic [NUM_OC-1:0] gnt_s;
  logic              any_gnt_s;
  logic [CTRL_W-1:0] sel_ctrl_s;
  logic [VEC_W-1:0]  sel_src1_s;
  logic [VEC_W-1:0]  sel_src2_s;

  assign hold_s     = valid_r & needs_cdb(ctrl_r) & CDB_Stall_MULT_Arb;
  assign can_load_s = ~hold_s;
  assign any_gnt_s  = |gnt_s;

  rr_arbiter #(.N(NUM_OC)) u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    (Valid_OC_Arb),
    .enable (can_load_s),
    .gnt    (gnt_s)
  );

  assign Grant_Arb_OC = gnt_s;

  // AND-OR select of the granted entry's payload; grant is one-hot.
  always_comb begin
    sel_ctrl_s = '0;
    sel_src1_s = '0;
    sel_src2_s = '0;
    for (int i = 0; i < NUM_OC; i++) begin
      sel_ctrl_s = sel_ctrl_s | ({CTRL_W{gnt_s[i]}} & Ctrl_OC_Arb[i*CTRL_W +: CTRL_W]);
      sel_src1_s = sel_src1_s | ({VEC_W{gnt_s[i]}} & Src1_Data_OC_Arb[i*VEC_W +: VEC_W]);
      sel_src2_s = sel_src2_s | ({VEC_W{gnt_s[i]}} & Src2_Data_OC_Arb[i*VEC_W +: VEC_W]);
    end
  end

  // Issue register: hold freezes it so the ALU's combinational result stays put.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      ctrl_r  <= '0;
      src1_r  <= '0;
      src2_r  <= '0;
    end else if (hold_s) begin
      valid_r <= valid_r;
      ctrl_r  <= ctrl_r;
      src1_r  <= src1_r;
      src2_r  <= src2_r;
    end else if (any_gnt_s) begin
      valid_r <= 1'b1;
      ctrl_r  <= sel_ctrl_s;
      src1_r  <= sel_src1_s;
      src2_r  <= sel_src2_s;
    end else begin
      valid_r <= 1'b0;
      ctrl_r  <= ctrl_r;
      src1_r  <= src1_r;
      src2_r  <= src2_r;
    end
  end

  assign Valid_Arb_ALU     = valid_r;
  assign Ctrl_Arb_ALU      = ctrl_r;
  assign Src1_Data_Arb_ALU = src1_r;
  assign Src2_Data_Arb_ALU = src2_r;

`ifdef ALU_ARB_PERF_EN
  logic [31:0] issue_cnt_r;
  logic [31:0] stall_cnt_r;

  // Free-running wrap-around counters of grants and held cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt_r <= 32'd0;
      stall_cnt_r <= 32'd0;
    end else begin
      issue_cnt_r <= any_gnt_s ? issue_cnt_r + 32'd1 : issue_cnt_r;
      stall_cnt_r <= hold_s ? stall_cnt_r + 32'd1 : stall_cnt_r;
    end
  end

  assign Perf_Issue_Cnt = issue_cnt_r;
  assign Perf_Stall_Cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Randomized self-checking bench for alu_issue_arbiter against a cycle-level
// reference model; directed scenarios precede a random phase.
module tb_alu_issue_arbiter;
  import alu_arb_pkg::*;

  localparam int NOC = 4;
  localparam int NT  = 8;
  localparam int DW  = 32;
  localparam int VW  = NT * DW;
  localparam int RW_B  = 8;
  localparam int BEQ_B = 3;
  localparam int BLT_B = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NOC-1:0]        Valid_OC_Arb = '0;
  logic [NOC*CTRL_W-1:0] Ctrl_OC_Arb = '0;
  logic [NOC*VW-1:0]     Src1_Data_OC_Arb = '0;
  logic [NOC*VW-1:0]     Src2_Data_OC_Arb = '0;
  logic [NOC-1:0]        Grant_Arb_OC;
  logic                  CDB_Stall_MULT_Arb = 1'b0;
  logic                  Valid_Arb_ALU;
  logic [CTRL_W-1:0]     Ctrl_Arb_ALU;
  logic [VW-1:0]         Src1_Data_Arb_ALU;
  logic [VW-1:0]         Src2_Data_Arb_ALU;
`ifdef ALU_ARB_PERF_EN
  logic [31:0]           Perf_Issue_Cnt;
  logic [31:0]           Perf_Stall_Cnt;
`endif

  alu_issue_arbiter #(.NUM_OC(NOC), .NUM_THREADS(NT), .DATA_WIDTH(DW)) dut (
    .clk                (clk),
    .rst                (rst),
    .Valid_OC_Arb       (Valid_OC_Arb),
    .Ctrl_OC_Arb        (Ctrl_OC_Arb),
    .Src1_Data_OC_Arb   (Src1_Data_OC_Arb),
    .Src2_Data_OC_Arb   (Src2_Data_OC_Arb),
    .Grant_Arb_OC       (Grant_Arb_OC),
    .CDB_Stall_MULT_Arb (CDB_Stall_MULT_Arb),
`ifdef ALU_ARB_PERF_EN
    .Perf_Issue_Cnt     (Perf_Issue_Cnt),
    .Perf_Stall_Cnt     (Perf_Stall_Cnt),
`endif
    .Valid_Arb_ALU      (Valid_Arb_ALU),
    .Ctrl_Arb_ALU       (Ctrl_Arb_ALU),
    .Src1_Data_Arb_ALU  (Src1_Data_Arb_ALU),
    .Src2_Data_Arb_ALU  (Src2_Data_Arb_ALU)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  int                m_ptr = 0;
  logic              m_valid = 1'b0;
  logic [CTRL_W-1:0] m_ctrl = '0;
  logic [VW-1:0]     m_src1 = '0;
  logic [VW-1:0]     m_src2 = '0;
  longint            m_issue = 0;
  longint            m_stall = 0;

  logic [CTRL_W-1:0] e_ctrl [NOC];
  logic [VW-1:0]     e_src1 [NOC];
  logic [VW-1:0]     e_src2 [NOC];

  task automatic check_eq(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: random control, 1: CDB-bound op, 2: BEQ branch
  task automatic fill_entries(input int mode);
    logic [95:0] r;
    for (int i = 0; i < NOC; i++) begin
      r = {$urandom(), $urandom(), $urandom()};
      e_ctrl[i] = r[CTRL_W-1:0];
      if (mode == 1) begin
        e_ctrl[i][RW_B] = 1'b1; e_ctrl[i][BEQ_B] = 1'b0; e_ctrl[i][BLT_B] = 1'b0;
      end else if (mode == 2) begin
        e_ctrl[i][RW_B] = 1'b1; e_ctrl[i][BEQ_B] = 1'b1;
      end
      for (int t = 0; t < NT; t++) begin
        e_src1[i][t*DW +: DW] = $urandom();
        e_src2[i][t*DW +: DW] = $urandom();
      end
      Ctrl_OC_Arb[i*CTRL_W +: CTRL_W] = e_ctrl[i];
      Src1_Data_OC_Arb[i*VW +: VW]    = e_src1[i];
      Src2_Data_OC_Arb[i*VW +: VW]    = e_src2[i];
    end
  endtask

  task automatic cycle(input logic [NOC-1:0] req, input logic stall, input logic r, input int mode);
    logic [NOC-1:0] exp_gnt;
    logic           hold;
    int             win;
    @(negedge clk);
    rst = r;
    Valid_OC_Arb = req;
    CDB_Stall_MULT_Arb = stall;
    fill_entries(mode);
    #1;
    hold = m_valid && m_ctrl[RW_B] && !m_ctrl[BEQ_B] && !m_ctrl[BLT_B] && stall;
    exp_gnt = '0;
    win = -1;
    if (!r && !hold) begin
      for (int k = 0; k < NOC; k++) begin
        if (win < 0 && req[(m_ptr + k) % NOC]) win = (m_ptr + k) % NOC;
      end
      if (win >= 0) exp_gnt[win] = 1'b1;
    end
    check_eq("grant", VW'(Grant_Arb_OC), VW'(exp_gnt));
    @(posedge clk);
    if (r) begin
      m_ptr = 0; m_valid = 1'b0; m_ctrl = '0; m_src1 = '0; m_src2 = '0;
      m_issue = 0; m_stall = 0;
    end else if (hold) begin
      m_stall++;
    end else if (win >= 0) begin
      m_valid = 1'b1; m_ctrl = e_ctrl[win]; m_src1 = e_src1[win]; m_src2 = e_src2[win];
      m_ptr = (win + 1) % NOC;
      m_issue++;
    end else begin
      m_valid = 1'b0;
    end
    #1;
    check_eq("valid", VW'(Valid_Arb_ALU), VW'(m_valid));
    check_eq("ctrl", VW'(Ctrl_Arb_ALU), VW'(m_ctrl));
    check_eq("src1", Src1_Data_Arb_ALU, m_src1);
    check_eq("src2", Src2_Data_Arb_ALU, m_src2);
`ifdef ALU_ARB_PERF_EN
    check_eq("issue_cnt", VW'(Perf_Issue_Cnt), VW'(m_issue[31:0]));
    check_eq("stall_cnt", VW'(Perf_Stall_Cnt), VW'(m_stall[31:0]));
`endif
  endtask

  initial begin
    // Reset with requests pending: no grants, cleared register
    cycle(4'hF, 1'b0, 1'b1, 0);
    cycle(4'hF, 1'b0, 1'b1, 0);
    // Single request on entry 2
    cycle(4'b0100, 1'b0, 1'b0, 1);
    cycle(4'b0000, 1'b0, 1'b0, 1);
    // Full contention from a fresh pointer
    cycle(4'hF, 1'b0, 1'b1, 1);
    for (int i = 0; i < 8; i++) cycle(4'hF, 1'b0, 1'b0, 1);
    // Stall on a CDB-bound op, then drain with a same-cycle grant
    cycle(4'hF, 1'b0, 1'b0, 1);
    for (int i = 0; i < 3; i++) cycle(4'hF, 1'b1, 1'b0, 1);
    cycle(4'hF, 1'b0, 1'b0, 1);
    // Branch in the register under stall is not held
    cycle(4'hF, 1'b0, 1'b0, 2);
    cycle(4'hF, 1'b1, 1'b0, 2);
    // Wrap: pointer at 3 with entries 0 and 1 requesting
    cycle(4'hF, 1'b0, 1'b1, 1);
    cycle(4'b0100, 1'b0, 1'b0, 1);
    cycle(4'b0011, 1'b0, 1'b0, 1);
    cycle(4'b0011, 1'b0, 1'b0, 1);
    // Reset in the middle of a hold
    cycle(4'hF, 1'b0, 1'b0, 1);
    cycle(4'hF, 1'b1, 1'b0, 1);
    cycle(4'hF, 1'b1, 1'b1, 1);
    cycle(4'hF, 1'b0, 1'b0, 1);
    // Random phase
    for (int i = 0; i < 400; i++) begin
      cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 4),
            ($urandom_range(0, 63) == 0), int'($urandom_range(0, 2)));
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_issue_arbiter.md
# alu_issue_arbiter

Issue controller sitting between the operand-collector (OC) entries and the ALU. Each cycle it selects one ready OC entry by round-robin, latches that entry's control word and operand vectors into a single issue register, and drives the ALU from that register. When the multiplier owns the CDB, it holds any CDB-bound op in place so the ALU's combinational result stays stable. Branch ops (BEQ/BLT) and non-writing ops bypass the hold because they never use the CDB.

## Interface
Parameters:
- NUM_OC, 4: number of OC entries competing for the ALU.
- NUM_THREADS, 8: lanes per warp.
- DATA_WIDTH, 32: bits per lane.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- Valid_OC_Arb  in  NUM_OC  bit i set: OC entry i holds a ready ALU op.
- Ctrl_OC_Arb  in  NUM_OC*CTRL_W  per-entry control word, entry i at [i*CTRL_W +: CTRL_W].
- Src1_Data_OC_Arb  in  NUM_OC*NUM_THREADS*DATA_WIDTH  per-entry operand 1.
- Src2_Data_OC_Arb  in  NUM_OC*NUM_THREADS*DATA_WIDTH  per-entry operand 2.
- Grant_Arb_OC  out  NUM_OC  one-hot, combinational. Entry consumed this cycle; the OC frees it next edge.
- CDB_Stall_MULT_Arb  in  1  CDB owned by the multiplier this cycle.
- Valid_Arb_ALU  out  1  issue register valid.
- Ctrl_Arb_ALU  out  CTRL_W  issued control word.
- Src1_Data_Arb_ALU, Src2_Data_Arb_ALU  out  NUM_THREADS*DATA_WIDTH  issued operands.
- Perf_Issue_Cnt, Perf_Stall_Cnt  out  32 each. Present only with ALU_ARB_PERF_EN.

## Operation
- Control word, MSB to LSB: WarpID[3], Instr[32], Dst[5], Imme[16], Imme_Valid, RegWrite, ALUop[4], BEQ, BLT, ScbID[2]. CTRL_W = 66.
- needs_cdb = RegWrite & ~BEQ & ~BLT, taken from the issue register.
- hold = Valid_Arb_ALU & needs_cdb & CDB_Stall_MULT_Arb.
- can_load = ~hold.
- Grant rule: if can_load and Valid_OC_Arb != 0, grant the first set bit at or after rr_ptr, scanning upward and wrapping NUM_OC-1 to 0. Otherwise Grant_Arb_OC = 0.
- rr_ptr ← (granted index + 1) mod NUM_OC on a grant. It is unchanged on no grant.
- Issue register at each edge:
  - hold: keep its contents.
  - else on a grant: load the granted entry and set Valid = 1.
  - else: Valid = 0. Data fields are don't-care but hold their last value.
- The arbiter does not inspect WarpID. Fairness is per OC entry only.

## Timing
- Grant is combinational from Valid_OC_Arb, rr_ptr and hold, in the same cycle as the request.
- The op appears on the *_Arb_ALU outputs at the next edge (latency 1 cycle). Throughput is 1 op/cycle.
- A held op drains in the first cycle where CDB_Stall_MULT_Arb = 0. A grant may occur in that same cycle.
- Empty issue register while stalled: a grant is still allowed, and stall is evaluated on the new op in the following cycle.
- Held branch or RegWrite=0 op: never held; it drains regardless of stall.
- Reset values: Valid_Arb_ALU = 0, Ctrl/Src outputs = 0, rr_ptr = 0, counters = 0. Grant_Arb_OC = 0 while rst = 1.
- Reset mid-hold discards the held op. The whole pipeline resets together, so no recovery is needed.

## Configuration
- ALU_ARB_PERF_EN defined:
  - Perf_Issue_Cnt increments on every grant.
  - Perf_Stall_Cnt increments on every cycle with hold = 1.
  - Both are 32-bit, wrap at 2^32-1 → 0, and clear on rst.
- ALU_ARB_PERF_EN undefined: both ports and both counters are absent. All other behaviour is identical.

## Structure
- Package alu_arb_pkg holds:
  - CTRL_W.
  - Field offset localparams (WARPID_LSB, INSTR_LSB, DST_LSB, IMME_LSB, IMMEV_BIT, REGWRITE_BIT, ALUOP_LSB, BEQ_BIT, BLT_BIT, SCBID_LSB).
  - needs_cdb function.
- Sub-module rr_arbiter #(N):
  - Inputs: req[N], enable, clk, rst.
  - Output: one-hot gnt[N].
  - Owns rr_ptr.
- Top level: hold logic, issue register, muxes, perf counters.

## Test plan
- Single request: Valid_OC_Arb = 4'b0100 with RegWrite=1 and no stall → Grant = 4'b0100 in the same cycle; next cycle Valid_Arb_ALU = 1 and Ctrl/Src match entry 2.
- Full contention: Valid_OC_Arb = 4'b1111 held for 8 cycles → grants in order 0,1,2,3,0,1,2,3. Perf_Issue_Cnt = 8 when ALU_ARB_PERF_EN is defined.
- Stall: CDB-bound op issued, then CDB_Stall_MULT_Arb = 1 for 3 cycles with all OCs requesting → Grant = 0 and outputs stable for 3 cycles; on the 4th cycle the next grant occurs. Perf_Stall_Cnt = 3.
- Branch under stall: BEQ=1 op in the register with stall = 1 → register not held; the next request is granted the same cycle.
- Wrap: rr_ptr = 3, Valid_OC_Arb = 4'b0011 → grant 0, then grant 1.
- Reset mid-hold: rst = 1 during a hold → next cycle Valid_Arb_ALU = 0 and counters = 0; after release, the first grant with all OCs requesting is entry 0.
